decimal_entry_accumulator: RTL and testbench

//   Builds a binary operand from decimal digits keyed in one at a time. Each accepted digit

---
 rtl/calc_pkg.sv | 7 +
 rtl/div10_serial.sv | 44 ++++
 rtl/decimal_entry_accumulator.sv | 83 ++++++++
 tb/tb_decimal_entry_accumulator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared widths, decimal base and entry FSM encoding for the calculator front end.
package calc_pkg;
  localparam int VAL_W = 40;
  localparam int DEC_BASE = 10;
  localparam int MAX_DIGITS = 6;
  typedef enum logic [1:0] {IDLE, DIV, DONE} entry_state_t;
endpackage

// File: rtl/div10_serial.sv
// div10_serial: bit-serial restoring divide-by-10, one quotient bit per cycle, MSB first.
import calc_pkg::*;
module div10_serial #(
  parameter int VAL_W = calc_pkg::VAL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [VAL_W-1:0] dividend,
  output logic [VAL_W-1:0] quotient,
  output logic             done
);
  localparam int NW = $clog2(VAL_W + 1);
  localparam logic [NW-1:0] LAST = NW'(VAL_W);
  logic [4:0] rem, trial;
  logic [NW-1:0] n;
  logic run, fit;
  // quotient doubles as the dividend shift register: dividend bits leave the top, quotient bits enter the bottom
  assign trial = 5'({rem, quotient[VAL_W-1]});
  assign fit = trial >= 5'(DEC_BASE);
  assign done = run && n == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      quotient <= '0;
      rem <= '0;
      n <= '0;
      run <= 1'b0;
    end else if (abort) begin
      run <= 1'b0;
      n <= '0;
    end else if (start) begin
      quotient <= dividend;
      rem <= '0;
      n <= '0;
      run <= 1'b1;
    end else if (done) begin
      run <= 1'b0;
    end else if (run) begin
      rem <= fit ? trial - 5'(DEC_BASE) : trial;
      quotient <= {quotient[VAL_W-2:0], fit};
      n <= n + 1'b1;
    end
endmodule

// File: rtl/decimal_entry_accumulator.sv
// decimal_entry_accumulator: builds a signed binary operand from keyed decimal digits with backspace, clear and sign.
import calc_pkg::*;
module decimal_entry_accumulator #(
  parameter int VAL_W = calc_pkg::VAL_W,
  parameter int MAX_DIGITS = calc_pkg::MAX_DIGITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        i_digit,
  input  logic                              i_digit_valid,
  input  logic                              i_backspace,
  input  logic                              i_clear,
  input  logic                              i_sign_toggle,
  output logic [VAL_W-1:0]                  o_value,
  output logic                              o_sign,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   o_digit_count,
  output logic                              o_busy,
  output logic                              o_err
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_DIGITS);
  entry_state_t state, state_n;
  logic [VAL_W-1:0] value_n, value_x10, quotient;
  logic [CW-1:0] count_n;
  logic sign_n, err_n, start, done;
  assign value_x10 = VAL_W'(({4'b0, o_value} << 3) + ({4'b0, o_value} << 1));
  assign o_busy = state != IDLE;
  div10_serial #(.VAL_W(VAL_W)) u_div (
    .clk(clk), .rst(rst), .start(start), .abort(i_clear),
    .dividend(o_value), .quotient(quotient), .done(done)
  );
  always_comb begin
    state_n = state;
    value_n = o_value;
    count_n = o_digit_count;
    sign_n = o_sign;
    err_n = o_err;
    start = 1'b0;
    if (i_clear) begin
      state_n = IDLE;
      value_n = '0;
      count_n = '0;
      sign_n = 1'b0;
      err_n = 1'b0;
    end else if (state == IDLE) begin
      sign_n = (i_sign_toggle && o_value != '0) ? ~o_sign : o_sign;
      if (i_backspace) begin
        start = o_digit_count != '0;
        state_n = start ? DIV : IDLE;
      end else if (i_digit_valid) begin
        if (i_digit > 4'(DEC_BASE - 1) || o_digit_count == FULL)
          err_n = 1'b1;
        else if (o_value != '0 || i_digit != 4'd0) begin
          value_n = value_x10 + VAL_W'(i_digit);
          count_n = o_digit_count + 1'b1;
        end
      end
    end else if (state == DIV) begin
      if (done) begin
        state_n = DONE;
        value_n = quotient;
        count_n = o_digit_count - 1'b1;
        sign_n = quotient == '0 ? 1'b0 : o_sign;
      end
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      o_value <= '0;
      o_digit_count <= '0;
      o_sign <= 1'b0;
      o_err <= 1'b0;
    end else begin
      state <= state_n;
      o_value <= value_n;
      o_digit_count <= count_n;
      o_sign <= sign_n;
      o_err <= err_n;
    end
endmodule

// File: tb/tb_decimal_entry_accumulator.sv
// tb_decimal_entry_accumulator: table vectors, hand-written multi-cycle sequences and a randomized model comparison.
module tb_decimal_entry_accumulator;
  localparam int W = 40;
  localparam int MD = 6;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] digit = '0;
  logic dv = 1'b0, bs = 1'b0, clr = 1'b0, tg = 1'b0;
  logic [W-1:0] value;
  logic sign, busy, err;
  logic [2:0] cnt;
  int checks = 0, errors = 0;
  longint mv, mp;
  int mc, mb;
  bit ms, me;
  typedef struct {
    bit c, b, v, t;
    logic [3:0] d;
    longint ev;
    bit es;
    int ec;
    bit ee;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  decimal_entry_accumulator #(.VAL_W(W), .MAX_DIGITS(MD)) dut (
    .clk(clk), .rst(rst), .i_digit(digit), .i_digit_valid(dv), .i_backspace(bs),
    .i_clear(clr), .i_sign_toggle(tg), .o_value(value), .o_sign(sign),
    .o_digit_count(cnt), .o_busy(busy), .o_err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input longint v, input bit s, input int c, input bit b, input bit e);
    chk({tag, ".value"}, value, v);
    chk({tag, ".sign"}, sign, s);
    chk({tag, ".count"}, cnt, c);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".err"}, err, e);
  endtask

  task automatic model_reset();
    mv = 0; mp = 0; mc = 0; mb = 0; ms = 0; me = 0;
  endtask

  // Timeline model: a backspace books W+2 busy cycles and the quotient lands one edge before busy ends.
  task automatic model_step(input bit c, b, v, t, input int d);
    if (c) model_reset();
    else if (mb > 0) begin
      mb--;
      if (mb == 1) begin
        mv = mp;
        mc--;
        if (mv == 0) ms = 0;
      end
    end else begin
      if (t && mv != 0) ms = !ms;
      if (b) begin
        if (mc > 0) begin
          mb = W + 2;
          mp = mv / 10;
        end
      end else if (v) begin
        if (d > 9 || mc == MD) me = 1;
        else if (!(mv == 0 && d == 0)) begin
          mv = mv * 10 + d;
          mc++;
        end
      end
    end
  endtask

  task automatic step(input bit c, b, v, t, input logic [3:0] d);
    clr = c; bs = b; dv = v; tg = t; digit = d;
    model_step(c, b, v, t, int'(d));
    @(posedge clk);
    #1;
    clr = 0; bs = 0; dv = 0; tg = 0;
    @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    step(0, 0, 1, 0, d);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 4'd0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      n++;
      idle();
    end
    chk("busy_timeout", busy, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tbl.push_back('{1,0,0,0,4'd0, 0,0,0,0});
    tbl.push_back('{0,0,1,0,4'd1, 1,0,1,0});
    tbl.push_back('{0,0,1,0,4'd2, 12,0,2,0});
    tbl.push_back('{0,0,1,0,4'd3, 123,0,3,0});
    tbl.push_back('{1,0,0,0,4'd0, 0,0,0,0});
    tbl.push_back('{0,0,1,0,4'd9, 9,0,1,0});
    tbl.push_back('{0,0,1,0,4'd8, 98,0,2,0});
    tbl.push_back('{0,0,1,0,4'd7, 987,0,3,0});
    tbl.push_back('{0,0,1,0,4'd6, 9876,0,4,0});
    tbl.push_back('{0,0,1,0,4'd5, 98765,0,5,0});
    tbl.push_back('{0,0,1,0,4'd4, 987654,0,6,0});
    tbl.push_back('{0,0,1,0,4'd3, 987654,0,6,1});
    tbl.push_back('{1,0,0,0,4'd0, 0,0,0,0});
    tbl.push_back('{0,0,1,0,4'd0, 0,0,0,0});
    tbl.push_back('{0,0,1,0,4'd0, 0,0,0,0});
    tbl.push_back('{0,0,1,0,4'd7, 7,0,1,0});
    tbl.push_back('{0,0,1,0,4'hA, 7,0,1,1});
    tbl.push_back('{1,0,0,0,4'd0, 0,0,0,0});
    tbl.push_back('{0,0,0,1,4'd0, 0,0,0,0});
    tbl.push_back('{0,0,1,0,4'd4, 4,0,1,0});
    tbl.push_back('{0,0,1,0,4'd2, 42,0,2,0});
    tbl.push_back('{0,0,0,1,4'd0, 42,1,2,0});
    tbl.push_back('{0,0,1,1,4'd1, 421,0,3,0});
    tbl.push_back('{1,0,1,1,4'd5, 0,0,0,0});
    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].b, tbl[i].v, tbl[i].t, tbl[i].d);
      check_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es, tbl[i].ec, 0, tbl[i].ee);
    end
    // backspace timing, value hold and dropped digit during the division
    step(1, 0, 0, 0, 0); key(1); key(2); key(3);
    step(0, 1, 0, 0, 0);
    n = busy ? 1 : 0;
    for (int i = 0; i < 200 && busy; i++) begin
      if (i == 20) chk("t2.hold", value, 123);
      if (i == 10) key(5); else idle();
      if (busy) n++;
    end
    chk("t2.busy_cycles", n, W + 2);
    check_all("t2.end", 12, 0, 2, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int d = 9; d >= 3; d--) key(4'(d));
    step(0, 1, 0, 0, 0);
    wait_idle(n);
    check_all("t3.bs", 98765, 0, 5, 0, 1);
    step(1, 0, 0, 0, 0);
    chk("t3.clr_err", err, 0);
    key(4); key(2);
    step(0, 0, 0, 1, 0);
    chk("t5.sign", sign, 1);
    step(0, 1, 0, 0, 0); wait_idle(n);
    check_all("t5.bs1", 4, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0); wait_idle(n);
    check_all("t5.bs2", 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("t5.tog0", sign, 0);
    step(0, 1, 0, 0, 0);
    chk("t5.bs_empty", busy, 0);
    key(5); key(5); key(5);
    step(0, 1, 0, 0, 0);
    repeat (10) idle();
    chk("t6.busy_mid", busy, 1);
    chk("t6.val_mid", value, 555);
    step(1, 0, 0, 0, 0);
    check_all("t6.abort", 0, 0, 0, 0, 0);
    key(7);
    step(0, 1, 0, 0, 0); wait_idle(n);
    check_all("t6.redo", 0, 0, 0, 0, 0);
    key(1); key(2);
    #2 rst = 1'b1;
    #1 check_all("t6.async_rst", 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) == 0, 4'($urandom_range(0, 10)));
      check_all("rnd", mv, ms, mc, mb > 0, me);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
